// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    WRITE,
    DONE,
    CSUM
  } state_t;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned LEN_W          = 16;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the loader.
// slave: the loader side; master: the stream source / memory observer.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output s_valid, s_data,
    input  s_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// 8->32 MSB-first shift register. word_full flags the beat that completes a word.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0]  cnt;
  logic [31:0] sr;

  // Shift bytes in from the bottom so byte0 ends up in [31:24].
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      sr  <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (shift_en) begin
      sr  <= {sr[23:0], byte_in};
      cnt <= cnt + 2'd1;
    end
  end

  // Full on the beat that carries the last byte of the word.
  always_comb begin
    word      = sr;
    word_full = shift_en && (cnt == 2'(BYTES_PER_WORD - 1));
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: length header + packed words from a byte stream,
// holds the core in reset until a load completes cleanly.
// Optional checksum trailer byte: define IMEM_LOADER_CSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  imem_loader_if.slave   bus,
  output logic           core_rst,
  output logic           done,
  output logic           err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  state_t            state, state_nx;
  logic              beat;
  logic [7:0]        len_hi_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  wcnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              err_q;
  logic [LEN_W-1:0]  n_rx;
  logic              len_zero;
  logic              len_over;
  logic              last_word;
  logic [31:0]       word;
  logic              word_full;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]        csum_q;
`endif

  byte_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .clear    ((state == LEN_LO) && beat),
    .shift_en ((state == DATA) && beat),
    .byte_in  (bus.s_data),
    .word     (word),
    .word_full(word_full)
  );

  // Header decode and word-count bookkeeping.
  always_comb begin
    beat      = bus.s_valid & bus.s_ready;
    n_rx      = LEN_W'({len_hi_q, bus.s_data});
    len_zero  = (n_rx == '0);
    len_over  = (32'(n_rx) > DEPTH);
    last_word = ((wcnt_q + LEN_W'(1)) == len_q);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (start) state_nx = LEN_HI;
      LEN_HI: if (beat) state_nx = LEN_LO;
      LEN_LO: begin
        if (beat) begin
          if (len_over)      state_nx = DONE;
`ifdef IMEM_LOADER_CSUM_EN
          else if (len_zero) state_nx = CSUM;
`else
          else if (len_zero) state_nx = DONE;
`endif
          else               state_nx = DATA;
        end
      end
      DATA:   if (word_full) state_nx = WRITE;
      WRITE: begin
`ifdef IMEM_LOADER_CSUM_EN
        state_nx = last_word ? CSUM : DATA;
`else
        state_nx = last_word ? DONE : DATA;
`endif
      end
      DONE:   if (start) state_nx = LEN_HI;
`ifdef IMEM_LOADER_CSUM_EN
      CSUM:   if (beat) state_nx = DONE;
`endif
      default: state_nx = IDLE;
    endcase
  end

  // Moore outputs decoded from the state.
  always_comb begin
    bus.s_ready    = 1'b0;
    bus.imem_we    = (state == WRITE);
    bus.imem_addr  = addr_q;
    bus.imem_wdata = word;
    done           = (state == DONE);
    err            = err_q;
    core_rst       = !((state == DONE) && !err_q);
    unique case (state)
      LEN_HI, LEN_LO, DATA: bus.s_ready = 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
      CSUM:                 bus.s_ready = 1'b1;
`endif
      default:              bus.s_ready = 1'b0;
    endcase
  end

  // Length, counters, write address, error flag and checksum.
  // The address is latched on the completing byte beat so it is already
  // valid during WRITE and then holds until the next word completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_hi_q <= '0;
      len_q    <= '0;
      wcnt_q   <= '0;
      addr_q   <= '0;
      err_q    <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      if (((state == IDLE) || (state == DONE)) && start) err_q <= 1'b0;
      if ((state == LEN_HI) && beat) len_hi_q <= bus.s_data;
      if ((state == LEN_LO) && beat) begin
        len_q  <= n_rx;
        wcnt_q <= '0;
        if (len_over) err_q <= 1'b1;
      end
      if (word_full) addr_q <= wcnt_q[ADDR_W-1:0];
      if (state == WRITE) wcnt_q <= wcnt_q + LEN_W'(1);
`ifdef IMEM_LOADER_CSUM_EN
      if ((state == LEN_LO) && beat) csum_q <= '0;
      if ((state == DATA) && beat)   csum_q <= csum_q ^ bus.s_data;
      if ((state == CSUM) && beat && (bus.s_data != csum_q)) err_q <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (both with and without IMEM_LOADER_CSUM_EN).
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int unsigned ADDR_W = 8;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic core_rst;
  logic done;
  logic err;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bus     (bus),
    .core_rst(core_rst),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [ADDR_W-1:0] wr_addr[$];
  logic [31:0]       wr_data[$];

  // Record every write pulse away from the active edge.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      wr_addr.push_back(bus.imem_addr);
      wr_data.push_back(bus.imem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the byte is accepted.
  task automatic send_byte(input logic [7:0] b);
    int unsigned guard;
    guard = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    @(negedge clk);
    while (bus.s_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("send_timeout", 32'(bus.s_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int unsigned guard;
    guard = 0;
    while (done !== 1'b1 && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  initial begin
    int seq_bad;
    rst         = 1'b1;
    start       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: reset state and idle
    check("t1_core_rst", 32'(core_rst), 32'd1);
    check("t1_done", 32'(done), 32'd0);
    check("t1_err", 32'(err), 32'd0);
    check("t1_s_ready", 32'(bus.s_ready), 32'd0);
    check("t1_addr", 32'(bus.imem_addr), 32'd0);
    check("t1_wdata", bus.imem_wdata, 32'd0);
    repeat (20) @(posedge clk);
    #1;
    check("t1_idle_we", 32'(wr_addr.size()), 32'd0);
    check("t1_idle_ready", 32'(bus.s_ready), 32'd0);
    check("t1_idle_core_rst", 32'(core_rst), 32'd1);

    // 2: two-word load, with an ignored start mid-load
    clear_log();
    pulse_start();
    check("t2_ready_len_hi", 32'(bus.s_ready), 32'd1);
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h20); send_byte(8'h08);
    pulse_start();
    send_byte(8'h00); send_byte(8'h05);
    send_byte(8'h01); send_byte(8'h09); send_byte(8'h50); send_byte(8'h20);
`ifdef IMEM_LOADER_CSUM_EN
    send_byte(8'h55);
`endif
    wait_done("t2_done");
    check("t2_err", 32'(err), 32'd0);
    check("t2_core_rst", 32'(core_rst), 32'd0);
    check("t2_ready_done", 32'(bus.s_ready), 32'd0);
    check("t2_we_count", 32'(wr_addr.size()), 32'd2);
    check("t2_addr_hold", 32'(bus.imem_addr), 32'd1);
    if (wr_addr.size() >= 2) begin
      check("t2_addr0", 32'(wr_addr[0]), 32'd0);
      check("t2_data0", wr_data[0], 32'h20080005);
      check("t2_addr1", 32'(wr_addr[1]), 32'd1);
      check("t2_data1", wr_data[1], 32'h01095020);
    end

    // 3: zero-length load
    clear_log();
    pulse_start();
    check("t3_done_cleared", 32'(done), 32'd0);
    check("t3_core_rst_on_start", 32'(core_rst), 32'd1);
    send_byte(8'h00); send_byte(8'h00);
`ifdef IMEM_LOADER_CSUM_EN
    send_byte(8'h00);
`endif
    wait_done("t3_done");
    check("t3_err", 32'(err), 32'd0);
    check("t3_core_rst", 32'(core_rst), 32'd0);
    check("t3_we_count", 32'(wr_addr.size()), 32'd0);

    // 4: oversize length 257
    clear_log();
    pulse_start();
    send_byte(8'h01); send_byte(8'h01);
    check("t4_done", 32'(done), 32'd1);
    check("t4_err", 32'(err), 32'd1);
    check("t4_core_rst", 32'(core_rst), 32'd1);
    check("t4_ready", 32'(bus.s_ready), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("t4_we_count", 32'(wr_addr.size()), 32'd0);

    // 4b: exactly full memory (256 words), last address 255, no wrap
    clear_log();
    pulse_start();
    check("t4b_err_cleared", 32'(err), 32'd0);
    send_byte(8'h01); send_byte(8'h00);
    for (int i = 0; i < 256; i++) begin
      send_byte(8'(i));
      send_byte(~8'(i));
      send_byte(8'(i));
      send_byte(8'h5A);
    end
`ifdef IMEM_LOADER_CSUM_EN
    send_byte(8'h00);
`endif
    wait_done("t4b_done");
    check("t4b_err", 32'(err), 32'd0);
    check("t4b_core_rst", 32'(core_rst), 32'd0);
    check("t4b_we_count", 32'(wr_addr.size()), 32'd256);
    check("t4b_addr_hold", 32'(bus.imem_addr), 32'd255);
    if (wr_addr.size() == 256) begin
      seq_bad = 0;
      for (int i = 0; i < 256; i++) if (wr_addr[i] !== 8'(i)) seq_bad++;
      check("t4b_addr_seq", 32'(seq_bad), 32'd0);
      check("t4b_data0", wr_data[0], 32'h00FF005A);
      check("t4b_data255", wr_data[255], 32'hFF00FF5A);
    end

    // 5: stalled stream then reset mid-word, followed by a clean reload
    clear_log();
    pulse_start();
    send_byte(8'h00); @(posedge clk); #1;
    send_byte(8'h01); @(posedge clk); #1;
    send_byte(8'hAA); @(posedge clk); #1;
    check("t5_ready_stall", 32'(bus.s_ready), 32'd1);
    send_byte(8'hBB); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t5_ready_after_rst", 32'(bus.s_ready), 32'd0);
    check("t5_done_after_rst", 32'(done), 32'd0);
    check("t5_core_rst_after_rst", 32'(core_rst), 32'd1);
    check("t5_wdata_after_rst", bus.imem_wdata, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("t5_no_partial_write", 32'(wr_addr.size()), 32'd0);
    pulse_start();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
`ifdef IMEM_LOADER_CSUM_EN
    send_byte(8'h08);
`endif
    wait_done("t5_reload_done");
    check("t5_reload_err", 32'(err), 32'd0);
    check("t5_reload_we_count", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() >= 1) begin
      check("t5_reload_addr", 32'(wr_addr[0]), 32'd0);
      check("t5_reload_data", wr_data[0], 32'h12345678);
    end

`ifdef IMEM_LOADER_CSUM_EN
    // 6: checksum match and mismatch
    clear_log();
    pulse_start();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    send_byte(8'h00);
    wait_done("t6_ok_done");
    check("t6_ok_err", 32'(err), 32'd0);
    check("t6_ok_core_rst", 32'(core_rst), 32'd0);
    clear_log();
    pulse_start();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    send_byte(8'h01);
    wait_done("t6_bad_done");
    check("t6_bad_err", 32'(err), 32'd1);
    check("t6_bad_core_rst", 32'(core_rst), 32'd1);
    check("t6_bad_we_count", 32'(wr_addr.size()), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
